// File: rtl/amo_controller_if.sv
// ============================================================================
// amo_controller_if : shared types and the atomic-sequencer bus interface
// Revision: 1.0
// ============================================================================
`default_nettype none

package amo_pkg;

  typedef enum logic [4:0] {
    INSTR_NOP,
    ADD,
    LW,
    SW,
    LR_W,
    SC_W,
    AMOSWAP,
    AMOADD,
    AMOOR,
    AMOXOR,
    AMOAND,
    AMOMAX,
    AMOMINI,
    AMOMINU,
    AMOMAXU
  } instr_name_t;

  typedef enum logic [1:0] {
    STATE0,
    STATE1,
    STATE2,
    STATE3
  } fsm_state;

  typedef struct packed {
    logic       amo_stall;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic       MemtoReg;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       dmem_wr_data_sel;
    logic       regfile_rd_addr_sel;
    logic [1:0] is_sc_reg_wr;
  } amo_controls_t;

endpackage

interface amo_controller_if #(
  parameter int XLEN = 32
) ();
  import amo_pkg::*;

  logic                  atomic_valid;
  instr_name_t           instr_name;
  logic [XLEN-1:0]       rs1_data;
  logic                  dmem_ready;
  logic                  resv_clear;
  amo_controls_t         amo_ctrl;
  logic                  resv_valid;
  logic [XLEN-1:0]       resv_addr;

  modport master (
    output atomic_valid, instr_name, rs1_data, dmem_ready, resv_clear,
    input  amo_ctrl, resv_valid, resv_addr
  );

  modport slave (
    input  atomic_valid, instr_name, rs1_data, dmem_ready, resv_clear,
    output amo_ctrl, resv_valid, resv_addr
  );

endinterface

`default_nettype wire

// File: rtl/amo_controller.sv
// ============================================================================
// amo_controller : multi-cycle LR.W / SC.W / AMO* sequencer with reservation
// Revision: 1.0
// ============================================================================
`default_nettype none

module amo_controller
  import amo_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RESV_LSB = 2
) (
  input  wire logic           clk,
  input  wire logic           rst,
  amo_controller_if.slave     bus
);

  localparam logic [XLEN-1:0] C_RESV_MASK = {XLEN{1'b1}} << RESV_LSB;

  fsm_state        state_q, state_d;
  logic            resv_valid_q, resv_valid_d;
  logic [XLEN-1:0] resv_addr_q, resv_addr_d;

  amo_controls_t   ctrl_w;
  logic            is_lr_w, is_sc_w, is_amo_w, start_w;
  logic            addr_match_w, sc_success_w;
  logic            lr_done_w, sc_done_w;

  assign is_lr_w  = (bus.instr_name == LR_W);
  assign is_sc_w  = (bus.instr_name == SC_W);
  assign is_amo_w = bus.instr_name inside {AMOSWAP, AMOADD, AMOOR, AMOXOR, AMOAND,
                                           AMOMAX, AMOMINI, AMOMINU, AMOMAXU};
  assign start_w  = bus.atomic_valid & (is_lr_w | is_sc_w | is_amo_w);

  assign addr_match_w = ((bus.rs1_data ^ resv_addr_q) & C_RESV_MASK) == '0;
  assign sc_success_w = resv_valid_q & ~bus.resv_clear & addr_match_w;

  always_comb begin
    ctrl_w       = '0;
    state_d      = state_q;
    resv_valid_d = resv_valid_q;
    resv_addr_d  = resv_addr_q;
    lr_done_w    = 1'b0;
    sc_done_w    = 1'b0;

    case (state_q)
      STATE0: begin
        if (start_w) begin
          ctrl_w.amo_stall = 1'b1;
          state_d          = STATE1;
        end
      end

      STATE1: begin
        ctrl_w.amo_stall = 1'b1;
        if (is_sc_w) begin
          if (sc_success_w) begin
            ctrl_w.MemWrite = 1'b1;
            if (bus.dmem_ready) begin
              ctrl_w.RegWrite     = 1'b1;
              ctrl_w.is_sc_reg_wr = 2'b01;
              sc_done_w           = 1'b1;
            end
          end else begin
            // Failed SC never touches memory; it just writes 1 to rd.
            ctrl_w.RegWrite     = 1'b1;
            ctrl_w.is_sc_reg_wr = 2'b10;
            sc_done_w           = 1'b1;
          end
        end else if (is_lr_w || is_amo_w) begin
          ctrl_w.MemRead = 1'b1;
          if (bus.dmem_ready) begin
            ctrl_w.RegWrite = 1'b1;
            ctrl_w.MemtoReg = 1'b1;
            if (is_lr_w) begin
              lr_done_w = 1'b1;
            end else begin
              state_d = STATE2;
            end
          end
        end else begin
          ctrl_w.amo_stall = 1'b0;
          state_d          = STATE0;
        end
      end

      STATE2: begin
        ctrl_w.amo_stall = 1'b1;
        ctrl_w.ALUSrcA   = 2'b10;
        ctrl_w.ALUSrcB   = 2'b01;
        ctrl_w.ALUOp     = 2'b11;
        state_d          = STATE3;
      end

      STATE3: begin
        ctrl_w.amo_stall        = 1'b1;
        ctrl_w.MemWrite         = 1'b1;
        ctrl_w.dmem_wr_data_sel = 1'b1;
        if (bus.dmem_ready) begin
          ctrl_w.amo_stall = 1'b0;
          state_d          = STATE0;
        end
      end

      default: state_d = STATE0;
    endcase

    if (lr_done_w || sc_done_w) begin
      ctrl_w.amo_stall = 1'b0;
      state_d          = STATE0;
    end

    // An external invalidate outranks an LR completing in the same cycle.
    if (lr_done_w && !bus.resv_clear) begin
      resv_valid_d = 1'b1;
      resv_addr_d  = bus.rs1_data & C_RESV_MASK;
    end
    if (sc_done_w || bus.resv_clear) begin
      resv_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= STATE0;
      resv_valid_q <= 1'b0;
      resv_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      resv_valid_q <= resv_valid_d;
      resv_addr_q  <= resv_addr_d;
    end
  end

  assign bus.amo_ctrl   = rst ? '0 : ctrl_w;
  assign bus.resv_valid = resv_valid_q;
  assign bus.resv_addr  = resv_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_amo_controller.sv
// ============================================================================
// tb_amo_controller : scoreboard bench for the atomic sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_amo_controller;
  import amo_pkg::*;

  localparam int XLEN = 32;

  typedef logic [47:0] vec_t;

  typedef struct {
    logic        v;
    instr_name_t in;
    logic [31:0] a;
    logic        rdy;
    logic        clr;
    vec_t        e;
    string       nm;
  } cyc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  amo_controller_if #(.XLEN(XLEN)) bus ();

  amo_controller #(.XLEN(XLEN), .RESV_LSB(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  vec_t  sb[$];
  string sbn[$];
  cyc_t  plan[$];
  int    n_pass  = 0;
  int    n_total = 0;

  amo_controls_t c_zero, c_stall, c_lr_done, c_sc_ok, c_sc_fail;
  amo_controls_t c_rd_wait, c_rd_done, c_compute, c_st_wait, c_st_done;

  function automatic amo_controls_t ctl(input logic s, input logic rd, input logic wr,
                                        input logic rw, input logic m2r, input logic [1:0] a,
                                        input logic [1:0] b, input logic [1:0] op,
                                        input logic sel, input logic [1:0] sc);
    amo_controls_t c;
    c.amo_stall           = s;
    c.MemRead             = rd;
    c.MemWrite            = wr;
    c.RegWrite            = rw;
    c.MemtoReg            = m2r;
    c.ALUSrcA             = a;
    c.ALUSrcB             = b;
    c.ALUOp               = op;
    c.dmem_wr_data_sel    = sel;
    c.regfile_rd_addr_sel = 1'b0;
    c.is_sc_reg_wr        = sc;
    return c;
  endfunction

  function automatic vec_t ex(input amo_controls_t c, input logic rv, input logic [31:0] ra);
    return {c, rv, ra};
  endfunction

  function automatic vec_t obs();
    return {bus.amo_ctrl, bus.resv_valid, bus.resv_addr};
  endfunction

  function automatic cyc_t cy(input logic v, input instr_name_t in, input logic [31:0] a,
                              input logic rdy, input logic clr, input vec_t e, input string nm);
    cyc_t c;
    c.v = v; c.in = in; c.a = a; c.rdy = rdy; c.clr = clr; c.e = e; c.nm = nm;
    return c;
  endfunction

  task automatic drive(input cyc_t c);
    @(posedge clk);
    #1;
    bus.atomic_valid = c.v;
    bus.instr_name   = c.in;
    bus.rs1_data     = c.a;
    bus.dmem_ready   = c.rdy;
    bus.resv_clear   = c.clr;
    sb.push_back(c.e);
    sbn.push_back(c.nm);
  endtask

  task automatic test_reset();
    vec_t e; string nm;
    #3;
    sb.push_back(ex(c_zero, 1'b0, 32'h0)); sbn.push_back("rst_async");
    e = sb.pop_front(); nm = sbn.pop_front();
    n_total++;
    if (obs() !== e) $display("FAIL %s: got %h want %h", nm, obs(), e); else n_pass++;
    @(negedge clk);
    sb.push_back(ex(c_zero, 1'b0, 32'h0)); sbn.push_back("rst_held");
    e = sb.pop_front(); nm = sbn.pop_front();
    n_total++;
    if (obs() !== e) $display("FAIL %s: got %h want %h", nm, obs(), e); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.atomic_valid = 1'b0;
    plan.delete();
    plan.push_back(cy(1'b0, LR_W, 32'h10, 1'b1, 1'b0, ex(c_zero, 1'b0, 32'h0), "idle_novalid"));
    plan.push_back(cy(1'b1, ADD,  32'h10, 1'b1, 1'b0, ex(c_zero, 1'b0, 32'h0), "ignore_add"));
    plan.push_back(cy(1'b1, SW,   32'h10, 1'b1, 1'b0, ex(c_zero, 1'b0, 32'h0), "ignore_sw"));
    foreach (plan[i]) begin
      drive(plan[i]);
      @(negedge clk);
      e = sb.pop_front(); nm = sbn.pop_front();
      n_total++;
      if (obs() !== e) $display("FAIL %s: got %h want %h", nm, obs(), e); else n_pass++;
    end
  endtask

  task automatic test_lr();
    vec_t e; string nm;
    plan.delete();
    plan.push_back(cy(1'b1, LR_W, 32'h102, 1'b1, 1'b0, ex(c_stall,   1'b0, 32'h0),   "lr_c0"));
    plan.push_back(cy(1'b1, LR_W, 32'h102, 1'b1, 1'b0, ex(c_lr_done, 1'b0, 32'h0),   "lr_c1"));
    plan.push_back(cy(1'b0, INSTR_NOP, 32'h0, 1'b1, 1'b0, ex(c_zero, 1'b1, 32'h100), "lr_resv"));
    foreach (plan[i]) begin
      drive(plan[i]);
      @(negedge clk);
      e = sb.pop_front(); nm = sbn.pop_front();
      n_total++;
      if (obs() !== e) $display("FAIL %s: got %h want %h", nm, obs(), e); else n_pass++;
    end
  endtask

  task automatic test_sc_success_and_repeat();
    vec_t e; string nm;
    plan.delete();
    plan.push_back(cy(1'b1, SC_W, 32'h100, 1'b1, 1'b0, ex(c_stall,   1'b1, 32'h100), "sc_ok_c0"));
    plan.push_back(cy(1'b1, SC_W, 32'h100, 1'b1, 1'b0, ex(c_sc_ok,   1'b1, 32'h100), "sc_ok_c1"));
    plan.push_back(cy(1'b1, SC_W, 32'h100, 1'b1, 1'b0, ex(c_stall,   1'b0, 32'h100), "sc_rep_c0"));
    plan.push_back(cy(1'b1, SC_W, 32'h100, 1'b1, 1'b0, ex(c_sc_fail, 1'b0, 32'h100), "sc_rep_c1"));
    plan.push_back(cy(1'b0, INSTR_NOP, 32'h0, 1'b1, 1'b0, ex(c_zero, 1'b0, 32'h100), "sc_rep_idle"));
    foreach (plan[i]) begin
      drive(plan[i]);
      @(negedge clk);
      e = sb.pop_front(); nm = sbn.pop_front();
      n_total++;
      if (obs() !== e) $display("FAIL %s: got %h want %h", nm, obs(), e); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    vec_t e; string nm;
    plan.delete();
    plan.push_back(cy(1'b1, LR_W,   32'h300, 1'b1, 1'b0, ex(c_stall,   1'b0, 32'h100), "b2b_lr_c0"));
    plan.push_back(cy(1'b1, LR_W,   32'h300, 1'b1, 1'b0, ex(c_lr_done, 1'b0, 32'h100), "b2b_lr_c1"));
    plan.push_back(cy(1'b1, AMOADD, 32'h200, 1'b1, 1'b0, ex(c_stall,   1'b1, 32'h300), "add_s0"));
    plan.push_back(cy(1'b1, AMOADD, 32'h200, 1'b0, 1'b0, ex(c_rd_wait, 1'b1, 32'h300), "add_s1_wait0"));
    plan.push_back(cy(1'b1, AMOADD, 32'h200, 1'b0, 1'b0, ex(c_rd_wait, 1'b1, 32'h300), "add_s1_wait1"));
    plan.push_back(cy(1'b1, AMOADD, 32'h200, 1'b1, 1'b0, ex(c_rd_done, 1'b1, 32'h300), "add_s1_ready"));
    plan.push_back(cy(1'b1, AMOADD, 32'h200, 1'b1, 1'b0, ex(c_compute, 1'b1, 32'h300), "add_s2"));
    plan.push_back(cy(1'b1, AMOADD, 32'h200, 1'b1, 1'b0, ex(c_st_done, 1'b1, 32'h300), "add_s3"));
    plan.push_back(cy(1'b1, AMOXOR, 32'h204, 1'b1, 1'b0, ex(c_stall,   1'b1, 32'h300), "xor_s0"));
    plan.push_back(cy(1'b1, AMOXOR, 32'h204, 1'b1, 1'b0, ex(c_rd_done, 1'b1, 32'h300), "xor_s1"));
    plan.push_back(cy(1'b1, AMOXOR, 32'h204, 1'b0, 1'b0, ex(c_compute, 1'b1, 32'h300), "xor_s2"));
    plan.push_back(cy(1'b1, AMOXOR, 32'h204, 1'b0, 1'b0, ex(c_st_wait, 1'b1, 32'h300), "xor_s3_wait"));
    plan.push_back(cy(1'b1, AMOXOR, 32'h204, 1'b1, 1'b0, ex(c_st_done, 1'b1, 32'h300), "xor_s3_done"));
    plan.push_back(cy(1'b0, INSTR_NOP, 32'h0, 1'b1, 1'b0, ex(c_zero,   1'b1, 32'h300), "amo_idle"));
    foreach (plan[i]) begin
      drive(plan[i]);
      @(negedge clk);
      e = sb.pop_front(); nm = sbn.pop_front();
      n_total++;
      if (obs() !== e) $display("FAIL %s: got %h want %h", nm, obs(), e); else n_pass++;
    end
  endtask

  task automatic test_sc_fail();
    vec_t e; string nm;
    plan.delete();
    plan.push_back(cy(1'b1, LR_W, 32'h100, 1'b1, 1'b0, ex(c_stall,   1'b1, 32'h300), "f_lr_c0"));
    plan.push_back(cy(1'b1, LR_W, 32'h100, 1'b1, 1'b0, ex(c_lr_done, 1'b1, 32'h300), "f_lr_c1"));
    plan.push_back(cy(1'b1, SC_W, 32'h104, 1'b1, 1'b0, ex(c_stall,   1'b1, 32'h100), "f_addr_c0"));
    plan.push_back(cy(1'b1, SC_W, 32'h104, 1'b1, 1'b0, ex(c_sc_fail, 1'b1, 32'h100), "f_addr_c1"));
    plan.push_back(cy(1'b1, LR_W, 32'h100, 1'b1, 1'b0, ex(c_stall,   1'b0, 32'h100), "f_lr2_c0"));
    plan.push_back(cy(1'b1, LR_W, 32'h100, 1'b1, 1'b0, ex(c_lr_done, 1'b0, 32'h100), "f_lr2_c1"));
    plan.push_back(cy(1'b1, SC_W, 32'h100, 1'b1, 1'b0, ex(c_stall,   1'b1, 32'h100), "f_clr_c0"));
    plan.push_back(cy(1'b1, SC_W, 32'h100, 1'b1, 1'b1, ex(c_sc_fail, 1'b1, 32'h100), "f_clr_c1"));
    plan.push_back(cy(1'b0, INSTR_NOP, 32'h0, 1'b1, 1'b0, ex(c_zero, 1'b0, 32'h100), "f_idle"));
    foreach (plan[i]) begin
      drive(plan[i]);
      @(negedge clk);
      e = sb.pop_front(); nm = sbn.pop_front();
      n_total++;
      if (obs() !== e) $display("FAIL %s: got %h want %h", nm, obs(), e); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_amo();
    vec_t e; string nm;
    plan.delete();
    plan.push_back(cy(1'b1, AMOSWAP, 32'h80, 1'b1, 1'b0, ex(c_stall,   1'b0, 32'h100), "swp_s0"));
    plan.push_back(cy(1'b1, AMOSWAP, 32'h80, 1'b1, 1'b0, ex(c_rd_done, 1'b0, 32'h100), "swp_s1"));
    plan.push_back(cy(1'b1, AMOSWAP, 32'h80, 1'b1, 1'b0, ex(c_compute, 1'b0, 32'h100), "swp_s2"));
    foreach (plan[i]) begin
      drive(plan[i]);
      @(negedge clk);
      e = sb.pop_front(); nm = sbn.pop_front();
      n_total++;
      if (obs() !== e) $display("FAIL %s: got %h want %h", nm, obs(), e); else n_pass++;
    end
    #1 rst = 1'b1;
    #1;
    sb.push_back(ex(c_zero, 1'b0, 32'h0)); sbn.push_back("swp_rst_immediate");
    e = sb.pop_front(); nm = sbn.pop_front();
    n_total++;
    if (obs() !== e) $display("FAIL %s: got %h want %h", nm, obs(), e); else n_pass++;
    @(negedge clk);
    sb.push_back(ex(c_zero, 1'b0, 32'h0)); sbn.push_back("swp_rst_no_store");
    e = sb.pop_front(); nm = sbn.pop_front();
    n_total++;
    if (obs() !== e) $display("FAIL %s: got %h want %h", nm, obs(), e); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.atomic_valid = 1'b0;
    plan.delete();
    plan.push_back(cy(1'b0, INSTR_NOP, 32'h0, 1'b1, 1'b0, ex(c_zero, 1'b0, 32'h0), "post_rst_idle"));
    plan.push_back(cy(1'b1, LR_W, 32'h47, 1'b1, 1'b0, ex(c_stall,   1'b0, 32'h0),   "post_lr_c0"));
    plan.push_back(cy(1'b1, LR_W, 32'h47, 1'b1, 1'b0, ex(c_lr_done, 1'b0, 32'h0),   "post_lr_c1"));
    plan.push_back(cy(1'b0, INSTR_NOP, 32'h0, 1'b1, 1'b0, ex(c_zero, 1'b1, 32'h44), "post_lr_resv"));
    foreach (plan[i]) begin
      drive(plan[i]);
      @(negedge clk);
      e = sb.pop_front(); nm = sbn.pop_front();
      n_total++;
      if (obs() !== e) $display("FAIL %s: got %h want %h", nm, obs(), e); else n_pass++;
    end
  endtask

  initial begin
    bus.atomic_valid = 1'b1;
    bus.instr_name   = LR_W;
    bus.rs1_data     = 32'h102;
    bus.dmem_ready   = 1'b1;
    bus.resv_clear   = 1'b0;

    c_zero    = '0;
    c_stall   = ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
    c_lr_done = ctl(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
    c_sc_ok   = ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01);
    c_sc_fail = ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b10);
    c_rd_wait = ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
    c_rd_done = ctl(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
    c_compute = ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b11, 1'b0, 2'b00);
    c_st_wait = ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00);
    c_st_done = ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00);

    test_reset();
    test_lr();
    test_sc_success_and_repeat();
    test_back_to_back();
    test_sc_fail();
    test_reset_mid_amo();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
